// File: rtl/uv_uart_arb.sv
// uv_uart_arb: round-robin arbiter sharing one uv_uart slave port among NREQ masters.
// Optional response timeout with error reply: define UV_UART_ARB_TMO_EN.
module uv_uart_arb #(
   parameter int NREQ    = 2,
   parameter int ALEN    = 12,
   parameter int DLEN    = 32,
   parameter int MLEN    = DLEN / 8,
   parameter int TMO_CYC = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      m_req_vld,
   output logic [NREQ-1:0]      m_req_rdy,
   input  logic [NREQ-1:0]      m_req_read,
   input  logic [NREQ*ALEN-1:0] m_req_addr,
   input  logic [NREQ*MLEN-1:0] m_req_mask,
   input  logic [NREQ*DLEN-1:0] m_req_data,
   output logic [NREQ-1:0]      m_rsp_vld,
   input  logic [NREQ-1:0]      m_rsp_rdy,
   output logic [1:0]           m_rsp_excp,
   output logic [DLEN-1:0]      m_rsp_data,
   output logic                 uart_req_vld,
   input  logic                 uart_req_rdy,
   output logic                 uart_req_read,
   output logic [ALEN-1:0]      uart_req_addr,
   output logic [MLEN-1:0]      uart_req_mask,
   output logic [DLEN-1:0]      uart_req_data,
   input  logic                 uart_rsp_vld,
   output logic                 uart_rsp_rdy,
   input  logic [1:0]           uart_rsp_excp,
   input  logic [DLEN-1:0]      uart_rsp_data
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] REQ  = 3'd1;
   localparam logic [2:0] RSP  = 3'd2;
`ifdef UV_UART_ARB_TMO_EN
   localparam logic [2:0] ERR   = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;
`endif

   logic [2:0]    state, state_nxt;
   logic [GW-1:0] gnt, ptr, pick, ptr_nxt;
   logic          req_act, rsp_act, err_act, drn_act, tmo_hit;
   int            idx;

   // scan from ptr upward; iterating downward lets the closest requester win
   always_comb begin
      pick = ptr;
      idx  = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         idx = (idx >= NREQ) ? idx - NREQ : idx;
         if (m_req_vld[idx]) pick = GW'(idx);
      end
   end

   assign ptr_nxt = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
   assign req_act = state == REQ;
   assign rsp_act = state == RSP;

`ifdef UV_UART_ARB_TMO_EN
   logic [15:0] tmo_cnt;
   assign err_act = state == ERR;
   assign drn_act = state == DRAIN;
   assign tmo_hit = rsp_act && !uart_rsp_vld && tmo_cnt == 16'(TMO_CYC - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt <= '0;
      else tmo_cnt <= !rsp_act ? '0 : uart_rsp_vld ? tmo_cnt : tmo_cnt + 1'b1;
   end
`else
   assign err_act = 1'b0;
   assign drn_act = 1'b0;
   assign tmo_hit = 1'b0;
`endif

   assign uart_req_vld  = req_act & m_req_vld[gnt];
   assign uart_req_read = req_act & m_req_read[gnt];
   assign uart_req_addr = req_act ? m_req_addr[gnt*ALEN +: ALEN] : '0;
   assign uart_req_mask = req_act ? m_req_mask[gnt*MLEN +: MLEN] : '0;
   assign uart_req_data = req_act ? m_req_data[gnt*DLEN +: DLEN] : '0;
   assign m_req_rdy     = req_act ? NREQ'(uart_req_rdy) << gnt : '0;
   assign m_rsp_vld     = (rsp_act || err_act) ? NREQ'(uart_rsp_vld | err_act) << gnt : '0;
   assign uart_rsp_rdy  = (rsp_act & m_rsp_rdy[gnt]) | drn_act;
   assign m_rsp_excp    = rsp_act ? uart_rsp_excp : err_act ? 2'b10 : 2'b00;
   assign m_rsp_data    = rsp_act ? uart_rsp_data : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = |m_req_vld ? REQ : IDLE;
         REQ:     state_nxt = (uart_req_vld && uart_req_rdy) ? RSP : REQ;
`ifdef UV_UART_ARB_TMO_EN
         RSP:     state_nxt = (uart_rsp_vld && m_rsp_rdy[gnt]) ? IDLE : tmo_hit ? ERR : RSP;
         ERR:     state_nxt = m_rsp_rdy[gnt] ? DRAIN : ERR;
         DRAIN:   state_nxt = uart_rsp_vld ? IDLE : DRAIN;
`else
         RSP:     state_nxt = (uart_rsp_vld && m_rsp_rdy[gnt]) ? IDLE : RSP;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && |m_req_vld) gnt <= pick;
         if (uart_req_vld && uart_req_rdy) ptr <= ptr_nxt;
      end
   end
endmodule

// File: tb/tb_uv_uart_arb.sv
// tb_uv_uart_arb: scoreboard bench for uv_uart_arb with NREQ=4 and a small uv_uart slave model.
module tb_uv_uart_arb;
   logic        clk = 0, rst_n = 0;
   logic [3:0]  m_req_vld = 0, m_req_rdy, m_req_read = 0, m_rsp_vld, m_rsp_rdy = 4'hF;
   logic [47:0] m_req_addr = 0;
   logic [15:0] m_req_mask = 0;
   logic [127:0] m_req_data = 0;
   logic [1:0]  m_rsp_excp;
   logic [31:0] m_rsp_data;
   logic        uart_req_vld, uart_req_rdy = 0, uart_req_read;
   logic [11:0] uart_req_addr;
   logic [3:0]  uart_req_mask;
   logic [31:0] uart_req_data;
   logic        uart_rsp_vld = 0, uart_rsp_rdy;
   logic [1:0]  uart_rsp_excp = 0;
   logic [31:0] uart_rsp_data = 0;

   uv_uart_arb #(.NREQ(4), .ALEN(12), .DLEN(32), .MLEN(4), .TMO_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_read(m_req_read),
      .m_req_addr(m_req_addr), .m_req_mask(m_req_mask), .m_req_data(m_req_data),
      .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_excp(m_rsp_excp), .m_rsp_data(m_rsp_data),
      .uart_req_vld(uart_req_vld), .uart_req_rdy(uart_req_rdy), .uart_req_read(uart_req_read),
      .uart_req_addr(uart_req_addr), .uart_req_mask(uart_req_mask), .uart_req_data(uart_req_data),
      .uart_rsp_vld(uart_rsp_vld), .uart_rsp_rdy(uart_rsp_rdy), .uart_rsp_excp(uart_rsp_excp),
      .uart_rsp_data(uart_rsp_data));

   always #5 clk = ~clk;

   typedef struct { int m; logic rd; logic [11:0] a; logic [3:0] k; logic [31:0] d; } req_t;
   typedef struct { int m; logic [1:0] e; logic [31:0] d; } rsp_t;
   req_t eq[$];
   rsp_t rq[$];

   int checks = 0, failures = 0;
   int left[4] = '{0, 0, 0, 0};
   int req_delay = 0, rsp_delay = 0, req_cnt = 0, rsp_cnt = 0;
   int rsp_wait = 0, last_wait = 0, rdy_pulses = 0;
   bit silent = 0, rsp_pend = 0, outst = 0;
   logic [3:0]  m_hs_s = 0;
   logic        req_vld_s = 0, req_hs_s = 0, rsp_hs_s = 0, s_read = 0;
   logic [11:0] s_addr = 0;
   logic [31:0] s_data = 0, pend_data = 0;
   logic [1:0]  pend_excp = 0;
   logic [31:0] mem [4096];

   task automatic cmp(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", n, act, exp);
      end
   endtask

   // monitor: samples on the falling edge, checks against the scoreboard queues
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_hs_s = 0; req_vld_s = 0; req_hs_s = 0; rsp_hs_s = 0;
      end else begin
         m_hs_s    = m_req_vld & m_req_rdy;
         req_vld_s = uart_req_vld;
         req_hs_s  = uart_req_vld & uart_req_rdy;
         rsp_hs_s  = uart_rsp_vld & uart_rsp_rdy;
         rdy_pulses += int'(m_req_rdy[0]);
         if (outst && m_rsp_vld == 0) rsp_wait++;
         cmp("onehot", {62'd0, $onehot0(m_req_rdy), $onehot0(m_rsp_vld)}, 64'd3);
         if (uart_req_vld) begin
            cmp("overlap", 64'(outst), 64'd0);
            if (eq.size() == 0) cmp("req_unexpected", 64'd1, 64'd0);
            else begin
               cmp("req_rdy", 64'(m_req_rdy), uart_req_rdy ? 64'(4'b1 << eq[0].m) : 64'd0);
               cmp("req_fields", {uart_req_read, uart_req_addr, uart_req_mask, uart_req_data},
                   {eq[0].rd, eq[0].a, eq[0].k, eq[0].d});
               if (req_hs_s) begin
                  void'(eq.pop_front());
                  s_read = uart_req_read; s_addr = uart_req_addr; s_data = uart_req_data;
                  outst = 1; rsp_wait = 0;
               end
            end
         end
         if (|(m_rsp_vld & m_rsp_rdy)) begin
            if (rq.size() == 0) cmp("rsp_unexpected", 64'd1, 64'd0);
            else begin
               cmp("rsp_master", 64'(m_rsp_vld), 64'(4'b1 << rq[0].m));
               cmp("rsp_fields", {m_rsp_excp, m_rsp_data}, {rq[0].e, rq[0].d});
               void'(rq.pop_front());
            end
            outst = 0; last_wait = rsp_wait;
         end
      end
   end

   // one clock: master hold/drop behaviour plus the uv_uart slave model
   task automatic tick();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         if (m_hs_s[i]) begin
            left[i]--;
            if (left[i] <= 0) m_req_vld[i] = 0;
         end
      if (rsp_hs_s) begin uart_rsp_vld = 0; rsp_pend = 0; end
      if (req_hs_s) begin
         uart_req_rdy = 0; req_cnt = 0; rsp_pend = 1; rsp_cnt = rsp_delay;
         pend_excp = (s_addr >= 12'hF00) ? 2'b01 : 2'b00;
         pend_data = s_read ? mem[s_addr] : 32'd0;
         if (!s_read) mem[s_addr] = s_data;
      end else if (req_vld_s && !uart_req_rdy) begin
         if (req_cnt >= req_delay) uart_req_rdy = 1;
         else req_cnt++;
      end
      if (rsp_pend && !uart_rsp_vld && !silent) begin
         if (rsp_cnt == 0) begin uart_rsp_vld = 1; uart_rsp_excp = pend_excp; uart_rsp_data = pend_data; end
         else rsp_cnt--;
      end
   endtask

   task automatic drive(int m, bit rd, logic [11:0] a, logic [31:0] d, logic [3:0] k, int n);
      m_req_read[m] = rd;
      m_req_addr[m*12 +: 12] = a;
      m_req_mask[m*4 +: 4] = k;
      m_req_data[m*32 +: 32] = d;
      left[m] = n;
      m_req_vld[m] = 1;
   endtask

   task automatic exp_txn(int m, bit rd, logic [11:0] a, logic [31:0] d, logic [3:0] k,
                          bit with_rsp, logic [1:0] e, logic [31:0] rdat);
      eq.push_back('{m: m, rd: rd, a: a, k: k, d: d});
      if (with_rsp) rq.push_back('{m: m, e: e, d: rdat});
   endtask

   task automatic wait_done(string n, int budget);
      bit ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         ok = eq.size() == 0 && rq.size() == 0 && m_req_vld == 0 && !outst;
      end
      cmp({n, "_done"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_outst(string n, int budget);
      for (int c = 0; c < budget && !outst; c++) tick();
      cmp({n, "_granted"}, 64'(outst), 64'd1);
   endtask

   task automatic check_zero(string n);
      cmp(n, {uart_req_vld, uart_req_read, uart_req_addr, uart_req_mask, m_req_rdy, m_rsp_vld,
              uart_rsp_rdy, m_rsp_excp, 32'(uart_req_data | m_rsp_data)}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 0;
      mem[12'h010] = 32'h5A;
      mem[12'hF04] = 32'h33;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_outputs");
      rst_n = 1;
      tick();
      check_zero("idle_outputs");

      // reset while in RSP: ptr was advanced to 3 by m2, must return to 0
      silent = 1;
      drive(2, 1, 12'h020, 0, 4'hF, 1);
      exp_txn(2, 1, 12'h020, 0, 4'hF, 0, 0, 0);
      wait_outst("t1", 20);
      tick(); tick();
      #2 rst_n = 0;
      #1 check_zero("reset_mid_rsp");
      rsp_pend = 0; uart_rsp_vld = 0; uart_req_rdy = 0; silent = 0; outst = 0;
      tick();
      rst_n = 1;
      tick();
      check_zero("after_reset");
      drive(1, 1, 12'h030, 0, 4'hF, 1);
      drive(3, 0, 12'h040, 32'h1234, 4'hF, 1);
      exp_txn(1, 1, 12'h030, 0, 4'hF, 1, 2'b00, 0);
      exp_txn(3, 0, 12'h040, 32'h1234, 4'hF, 1, 2'b00, 0);
      wait_done("t1", 60);

      // m0 and m1 continuously requesting: grants alternate 0,1,0,1
      drive(0, 0, 12'h104, 32'h11, 4'hF, 2);
      drive(1, 1, 12'h104, 0, 4'hF, 2);
      exp_txn(0, 0, 12'h104, 32'h11, 4'hF, 1, 2'b00, 0);
      exp_txn(1, 1, 12'h104, 0, 4'hF, 1, 2'b00, 32'h11);
      exp_txn(0, 0, 12'h104, 32'h11, 4'hF, 1, 2'b00, 0);
      exp_txn(1, 1, 12'h104, 0, 4'hF, 1, 2'b00, 32'h11);
      wait_done("t3", 80);

      // slow uart_req_rdy: request held, m_req_rdy[0] pulses exactly once
      req_delay = 3; rdy_pulses = 0;
      drive(0, 0, 12'h004, 32'hA5, 4'hF, 1);
      exp_txn(0, 0, 12'h004, 32'hA5, 4'hF, 1, 2'b00, 0);
      wait_done("t2", 40);
      cmp("t2_rdy_pulses", 64'(rdy_pulses), 64'd1);
      req_delay = 0;

      // m1 arrives during m0 RSP with m0 stalling its response for 5 cycles
      rsp_delay = 1;
      drive(0, 0, 12'h008, 32'h77, 4'hF, 1);
      exp_txn(0, 0, 12'h008, 32'h77, 4'hF, 1, 2'b00, 0);
      exp_txn(1, 1, 12'h010, 0, 4'hF, 1, 2'b00, 32'h5A);
      wait_outst("t4", 20);
      m_rsp_rdy[0] = 0;
      drive(1, 1, 12'h010, 0, 4'hF, 1);
      repeat (5) tick();
      cmp("t4_m0_pending", 64'(rq.size()), 64'd2);
      m_rsp_rdy[0] = 1;
      wait_done("t4", 40);
      rsp_delay = 0;

      // m0 read-back leaves ptr=1; then m3 and m0 together: m3 first, ptr wraps to 0
      drive(0, 1, 12'h004, 0, 4'hF, 1);
      exp_txn(0, 1, 12'h004, 0, 4'hF, 1, 2'b00, 32'hA5);
      wait_done("rdback", 30);
      drive(3, 1, 12'hF04, 0, 4'hF, 1);
      drive(0, 0, 12'h00C, 32'hBEEF, 4'h3, 1);
      exp_txn(3, 1, 12'hF04, 0, 4'hF, 1, 2'b01, 32'h33);
      exp_txn(0, 0, 12'h00C, 32'hBEEF, 4'h3, 1, 2'b00, 0);
      wait_done("t5", 40);

`ifdef UV_UART_ARB_TMO_EN
      // silent slave: 16 RSP cycles, error reply, late response drained
      silent = 1;
      drive(2, 1, 12'h020, 0, 4'hF, 1);
      exp_txn(2, 1, 12'h020, 0, 4'hF, 1, 2'b10, 0);
      wait_done("t6", 60);
      cmp("t6_rsp_cycles", 64'(last_wait), 64'd16);
      silent = 0;
      repeat (4) tick();
      cmp("t6_drained", 64'(uart_rsp_vld), 64'd0);
      drive(1, 1, 12'h010, 0, 4'hF, 1);
      exp_txn(1, 1, 12'h010, 0, 4'hF, 1, 2'b00, 32'h5A);
      wait_done("t6_after", 40);
`endif

      cmp("queues_empty", 64'(eq.size() + rq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
